// File: rtl/datapath_p3_pkg.sv
// Shared definitions for the datapath_p3 multi-cycle core: opcodes, branch
// condition codes, sequencer steps, one-hot ALU ops and the control strobe bundle.
package datapath_p3_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Branch condition codes, IR[20:19]
    localparam logic [1:0] C2_ZERO = 2'b00;
    localparam logic [1:0] C2_NZ   = 2'b01;
    localparam logic [1:0] C2_POS  = 2'b10;
    localparam logic [1:0] C2_NEG  = 2'b11;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_e;

    // One-hot ALU operation; bit order matches the AND..NOT output ports
    typedef logic [11:0] alu_op_t;
    localparam alu_op_t ALU_NONE = 12'h000;
    localparam alu_op_t ALU_AND  = 12'h001;
    localparam alu_op_t ALU_OR   = 12'h002;
    localparam alu_op_t ALU_ADD  = 12'h004;
    localparam alu_op_t ALU_SUB  = 12'h008;
    localparam alu_op_t ALU_MUL  = 12'h010;
    localparam alu_op_t ALU_DIV  = 12'h020;
    localparam alu_op_t ALU_SHR  = 12'h040;
    localparam alu_op_t ALU_SHL  = 12'h080;
    localparam alu_op_t ALU_ROR  = 12'h100;
    localparam alu_op_t ALU_ROL  = 12'h200;
    localparam alu_op_t ALU_NEG  = 12'h400;
    localparam alu_op_t ALU_NOT  = 12'h800;

    // Every strobe the sequencer can raise in one step
    typedef struct packed {
        logic    pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, inp_out;
        logic    mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outp_in;
        logic    inc_pc, rd, wr;
        logic    gra, grb, grc, r_in, r_out, ba_out, c_out;
        logic    con_ld;
        alu_op_t alu;
    } ctrl_t;

    function automatic alu_op_t op_alu(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: op_alu = ALU_ADD;
            OP_SUB:          op_alu = ALU_SUB;
            OP_AND, OP_ANDI: op_alu = ALU_AND;
            OP_OR, OP_ORI:   op_alu = ALU_OR;
            OP_SHR:          op_alu = ALU_SHR;
            OP_SHL:          op_alu = ALU_SHL;
            OP_ROR:          op_alu = ALU_ROR;
            OP_ROL:          op_alu = ALU_ROL;
            OP_MUL:          op_alu = ALU_MUL;
            OP_DIV:          op_alu = ALU_DIV;
            OP_NEG:          op_alu = ALU_NEG;
            OP_NOT:          op_alu = ALU_NOT;
            default:         op_alu = ALU_NONE;
        endcase
    endfunction

    // Final step of an instruction; nop, halt and undefined end with the fetch
    function automatic step_e last_step(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                             last_step = T7;
            OP_MUL, OP_DIV, OP_BR:                    last_step = T6;
            OP_NEG, OP_NOT:                           last_step = T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:   last_step = T3;
            OP_NOP, OP_HALT:                          last_step = T2;
            default: begin
                if (op >= OP_LDI && op <= OP_ORI) last_step = T5;
                else                              last_step = T2;
            end
        endcase
    endfunction

endpackage

// File: rtl/datapath_p3_alu.sv
// Combinational ALU: A is the Y register, B is the bus; 64-bit result for Z.
module datapath_p3_alu
    import datapath_p3_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    input  logic        inc_pc,
    input  logic [31:0] pc,
    output logic [63:0] z
);

    logic [4:0]         sh;
    logic [5:0]         sh_inv;
    logic signed [63:0] prod;
    logic signed [31:0] quo;
    logic signed [31:0] rem;

    assign sh     = b[4:0];
    assign sh_inv = 6'd32 - {1'b0, sh};
    assign prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign quo    = $signed(a) / $signed(b);
    assign rem    = $signed(a) % $signed(b);

    // Select the result; IncPC overrides the op so fetch can bump the PC
    always_comb begin
        z = 64'd0;
        if (inc_pc) begin
            z = {32'd0, pc + 32'd1};
        end else begin
            case (op)
                ALU_AND: z = {32'd0, a & b};
                ALU_OR:  z = {32'd0, a | b};
                ALU_ADD: z = {32'd0, a + b};
                ALU_SUB: z = {32'd0, a - b};
                ALU_MUL: z = prod;
                ALU_DIV: z = (b == 32'd0) ? {a, 32'd0} : {rem, quo};
                ALU_SHR: z = {32'd0, a >> sh};
                ALU_SHL: z = {32'd0, a << sh};
                ALU_ROR: z = {32'd0, (a >> sh) | (a << sh_inv)};
                ALU_ROL: z = {32'd0, (a << sh) | (a >> sh_inv)};
                ALU_NEG: z = {32'd0, -b};
                ALU_NOT: z = {32'd0, ~b};
                default: z = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/datapath_p3.sv
// Single-bus 32-bit multi-cycle core: register file, special registers,
// unified memory and a hardwired step sequencer whose strobes are all exported.
module datapath_p3
    import datapath_p3_pkg::*;
#(
    parameter string MEM_INIT  = "",
    parameter int    MEM_WORDS = 512
)
(
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    input  logic        ReadEn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    input  logic        CONin,
    input  logic        strobe,
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] InPortData,
    input  logic [31:0] ExtData,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        Run,
    input  logic        Stop,
    input  logic        CON_FF,
    input  logic        Interrupts
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [31:0] inport_q, inport_d, outport_q, outport_d;
    logic [63:0] z_q, z_d;
    logic        con_q, con_d, halted_q, halted_d;
    step_e       step_q, step_d;

    logic [31:0] mem [MEM_WORDS];

    ctrl_t       ctl;
    logic        run_w, cond_met;
    logic [4:0]  opcode;
    logic [3:0]  rsel;
    logic [31:0] rval, csext, bus, mem_rd;
    logic [63:0] alu_z;

    assign opcode = ir_q[31:27];
    assign run_w  = !halted_q && !Stop;
    assign rsel   = ({4{ctl.gra}} & ir_q[26:23]) | ({4{ctl.grb}} & ir_q[22:19])
                  | ({4{ctl.grc}} & ir_q[18:15]);
    assign rval   = regs_q[rsel];
    assign csext  = {{13{ir_q[18]}}, ir_q[18:0]};
    assign mem_rd = mem[mar_q[AW-1:0]];

    // Single bus: AND-OR of whichever source strobe is up
    assign bus = ({32{ctl.pc_out}}  & pc_q)        | ({32{ctl.zhi_out}} & z_q[63:32])
               | ({32{ctl.zlo_out}} & z_q[31:0])   | ({32{ctl.mdr_out}} & mdr_q)
               | ({32{ctl.hi_out}}  & hi_q)        | ({32{ctl.lo_out}}  & lo_q)
               | ({32{ctl.inp_out}} & inport_q)    | ({32{ctl.r_out}}   & rval)
               | ({32{ctl.ba_out && rsel != 4'd0}} & rval)
               | ({32{ctl.c_out}}   & csext);

    datapath_p3_alu u_alu (
        .a      (y_q),
        .b      (bus),
        .op     (ctl.alu),
        .inc_pc (ctl.inc_pc),
        .pc     (pc_q),
        .z      (alu_z)
    );

    // Branch condition of the bus value against IR[20:19]
    always_comb begin
        case (ir_q[20:19])
            C2_ZERO: cond_met = (bus == 32'd0);
            C2_NZ:   cond_met = (bus != 32'd0);
            C2_POS:  cond_met = !bus[31] && (bus != 32'd0);
            default: cond_met = bus[31];
        endcase
    end

    // Moore decode of step and IR into strobes; everything is quiet when not running
    always_comb begin
        ctl = '0;
        if (run_w) begin
            case (step_q)
                T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1; end
                T1: begin ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.rd = 1'b1; ctl.mdr_in = 1'b1; end
                T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
                default: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            case (step_q)
                                T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
                                T4: begin
                                    if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) ctl.c_out = 1'b1;
                                    else begin ctl.grc = 1'b1; ctl.r_out = 1'b1; end
                                    ctl.alu  = op_alu(opcode);
                                    ctl.z_in = 1'b1;
                                end
                                T5: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            case (step_q)
                                T3: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
                                T4: begin ctl.c_out = 1'b1; ctl.alu = ALU_ADD; ctl.z_in = 1'b1; end
                                T5: begin
                                    ctl.zlo_out = 1'b1;
                                    if (opcode == OP_LDI) begin ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                                    else ctl.mar_in = 1'b1;
                                end
                                T6: begin
                                    ctl.mdr_in = 1'b1;
                                    if (opcode == OP_LD) ctl.rd = 1'b1;
                                    else begin ctl.gra = 1'b1; ctl.r_out = 1'b1; end
                                end
                                T7: begin
                                    if (opcode == OP_LD) begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                                    else ctl.wr = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_MUL, OP_DIV: begin
                            case (step_q)
                                T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
                                T4: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.alu = op_alu(opcode); ctl.z_in = 1'b1; end
                                T5: begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
                                T6: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            case (step_q)
                                T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.alu = op_alu(opcode); ctl.z_in = 1'b1; end
                                T4: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            case (step_q)
                                T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_ld = 1'b1; end
                                T4: begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
                                T5: begin ctl.c_out = 1'b1; ctl.alu = ALU_ADD; ctl.z_in = 1'b1; end
                                T6: begin ctl.zlo_out = 1'b1; ctl.pc_in = con_q | CON_FF; end
                                default: ;
                            endcase
                        end
                        OP_JR:   if (step_q == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                        OP_IN:   if (step_q == T3) begin ctl.inp_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        OP_OUT:  if (step_q == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outp_in = 1'b1; end
                        OP_MFHI: if (step_q == T3) begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        OP_MFLO: if (step_q == T3) begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Sequencer: advance or wrap to T0; at T2 the fetched word in MDR decides nop/halt
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (run_w) begin
            if (step_q == last_step((step_q == T2) ? mdr_q[31:27] : opcode)) step_d = T0;
            else                                                             step_d = step_e'(step_q + 3'd1);
            if (step_q == T2 && mdr_q[31:27] == OP_HALT) halted_d = 1'b1;
        end
    end

    // Register load enables from the current strobes
    always_comb begin
        regs_d    = regs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        y_d       = y_q;
        z_d       = z_q;
        inport_d  = inport_q;
        outport_d = outport_q;
        con_d     = con_q;
        if (ctl.r_in)    regs_d[rsel] = bus;
        if (ctl.hi_in)   hi_d = bus;
        if (ctl.lo_in)   lo_d = bus;
        if (ctl.pc_in)   pc_d = bus;
        if (ctl.ir_in)   ir_d = bus;
        if (ctl.mar_in)  mar_d = bus;
        if (ctl.mdr_in)  mdr_d = ctl.rd ? (ReadEn ? ExtData : mem_rd) : bus;
        if (ctl.y_in)    y_d = bus;
        if (ctl.z_in)    z_d = alu_z;
        if (strobe)      inport_d = InPortData;
        if (ctl.outp_in) outport_d = bus;
        if (ctl.con_ld || CONin) con_d = cond_met;
    end

    // State registers with synchronous clear
    always_ff @(posedge Clock) begin
        if (Clear) begin
            regs_q    <= '{default: 32'd0};
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pc_q      <= 32'd0;
            ir_q      <= 32'd0;
            mar_q     <= 32'd0;
            mdr_q     <= 32'd0;
            y_q       <= 32'd0;
            z_q       <= 64'd0;
            inport_q  <= 32'd0;
            outport_q <= 32'd0;
            con_q     <= 1'b0;
            step_q    <= T0;
            halted_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            z_q       <= z_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            con_q     <= con_d;
            step_q    <= step_d;
            halted_q  <= halted_d;
        end
    end

    // Memory image at elaboration: zero-filled
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end

    // Synchronous store; a Clear in the same cycle abandons it
    always_ff @(posedge Clock) begin
        if (ctl.wr && !Clear) mem[mar_q[AW-1:0]] <= mdr_q;
    end

    assign PCout     = ctl.pc_out;
    assign Zhighout  = ctl.zhi_out;
    assign Zlowout   = ctl.zlo_out;
    assign MDRout    = ctl.mdr_out;
    assign HIout     = ctl.hi_out;
    assign LOout     = ctl.lo_out;
    assign InPortout = ctl.inp_out;
    assign MARin     = ctl.mar_in;
    assign Zin       = ctl.z_in;
    assign PCin      = ctl.pc_in;
    assign MDRin     = ctl.mdr_in;
    assign IRin      = ctl.ir_in;
    assign Yin       = ctl.y_in;
    assign HIin      = ctl.hi_in;
    assign LOin      = ctl.lo_in;
    assign OutPortin = ctl.outp_in;
    assign IncPC     = ctl.inc_pc;
    assign Read      = ctl.rd;
    assign Write     = ctl.wr;
    assign Gra       = ctl.gra;
    assign Grb       = ctl.grb;
    assign Grc       = ctl.grc;
    assign Rin       = ctl.r_in;
    assign Rout      = ctl.r_out;
    assign BAout     = ctl.ba_out;
    assign Cout      = ctl.c_out;
    assign AND       = ctl.alu[0];
    assign OR        = ctl.alu[1];
    assign ADD       = ctl.alu[2];
    assign SUB       = ctl.alu[3];
    assign MUL       = ctl.alu[4];
    assign DIV       = ctl.alu[5];
    assign SHR       = ctl.alu[6];
    assign SHL       = ctl.alu[7];
    assign ROR       = ctl.alu[8];
    assign ROL       = ctl.alu[9];
    assign NEG       = ctl.alu[10];
    assign NOT       = ctl.alu[11];
    assign Run       = run_w;

    // Interrupts is reserved; OutPort is observed only at system level
    logic unused_ok;
    assign unused_ok = ^{Interrupts, outport_q, mar_q[31:AW]};

endmodule

// File: tb/tb_datapath_p3.sv
// Directed program run on datapath_p3: fetch, ldi, add, ror, mul, div, st/ld,
// taken branch, halt freeze and Stop freeze, with hand-computed expectations.
module tb_datapath_p3;

    localparam logic [4:0] O_LD = 5'b00000, O_LDI = 5'b00001, O_ST = 5'b00010;
    localparam logic [4:0] O_ADD = 5'b00011, O_ROR = 5'b01001, O_MUL = 5'b01110;
    localparam logic [4:0] O_DIV = 5'b01111, O_BR = 5'b10010, O_HALT = 5'b11010;

    logic        clk = 1'b0;
    logic        clear, read_en, con_in, in_strobe, stop, con_ff, irq;
    logic [31:0] in_data, ext_data;
    logic        pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, inp_out;
    logic        mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outp_in;
    logic        inc_pc, rd, wr, gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic        op_and, op_or, op_add, op_sub, op_mul, op_div;
    logic        op_shr, op_shl, op_ror, op_rol, op_neg, op_not, run;
    logic [37:0] strobes;
    logic [37:0] exp_t0;
    logic [31:0] prog [14];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign strobes = {pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, inp_out,
                      mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outp_in,
                      inc_pc, rd, wr, gra, grb, grc, r_in, r_out, ba_out, c_out,
                      op_and, op_or, op_add, op_sub, op_mul, op_div,
                      op_shr, op_shl, op_ror, op_rol, op_neg, op_not};

    datapath_p3 dut (
        .PCout(pc_out), .Zhighout(zhi_out), .Zlowout(zlo_out), .MDRout(mdr_out),
        .HIout(hi_out), .LOout(lo_out), .InPortout(inp_out),
        .MARin(mar_in), .Zin(z_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in),
        .Yin(y_in), .HIin(hi_in), .LOin(lo_in), .OutPortin(outp_in),
        .IncPC(inc_pc), .Read(rd), .Write(wr), .ReadEn(read_en),
        .Gra(gra), .Grb(grb), .Grc(grc), .Rin(r_in), .Rout(r_out), .BAout(ba_out), .Cout(c_out),
        .CONin(con_in), .strobe(in_strobe), .Clock(clk), .Clear(clear),
        .InPortData(in_data), .ExtData(ext_data),
        .AND(op_and), .OR(op_or), .ADD(op_add), .SUB(op_sub), .MUL(op_mul), .DIV(op_div),
        .SHR(op_shr), .SHL(op_shl), .ROR(op_ror), .ROL(op_rol), .NEG(op_neg), .NOT(op_not),
        .Run(run), .Stop(stop), .CON_FF(con_ff), .Interrupts(irq)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One or more clock cycles; returns on the falling edge where outputs are stable
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reg(input string tag, input int idx);
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq(tag, dut.regs_q[idx], e);
    endtask

    initial begin
        int wcnt;
        int wstep;
        clear = 1'b1; read_en = 1'b0; con_in = 1'b0; in_strobe = 1'b0;
        stop = 1'b0; con_ff = 1'b0; irq = 1'b0; in_data = 32'd0; ext_data = 32'd0;
        exp_t0 = '0;
        exp_t0[37] = 1'b1; exp_t0[30] = 1'b1; exp_t0[29] = 1'b1; exp_t0[21] = 1'b1;

        prog[0]  = enc(O_LDI, 4'd2, 4'd0, 19'h00065);
        prog[1]  = enc(O_LDI, 4'd3, 4'd0, 19'h7FFFD);
        prog[2]  = enc(O_LDI, 4'd1, 4'd0, 19'h00004);
        prog[3]  = enc(O_ADD, 4'd4, 4'd2, {4'd3, 15'd0});
        prog[4]  = enc(O_ROR, 4'd5, 4'd2, {4'd1, 15'd0});
        prog[5]  = enc(O_MUL, 4'd2, 4'd3, 19'd0);
        prog[6]  = enc(O_DIV, 4'd2, 4'd3, 19'd0);
        prog[7]  = enc(O_ST,  4'd2, 4'd0, 19'h00040);
        prog[8]  = enc(O_LD,  4'd6, 4'd0, 19'h00040);
        prog[9]  = enc(O_BR,  4'd7, 4'd0, 19'h00002);
        prog[10] = enc(O_LDI, 4'd8, 4'd0, 19'h00011);
        prog[11] = enc(O_LDI, 4'd8, 4'd0, 19'h00022);
        prog[12] = enc(O_HALT, 4'd0, 4'd0, 19'd0);
        prog[13] = enc(O_LDI, 4'd9, 4'd0, 19'h00001);
        #1;
        for (int i = 0; i < 14; i++) dut.mem[i] <= prog[i];

        exp_q.push_back(32'h00000065);
        exp_q.push_back(32'hFFFFFFFD);
        exp_q.push_back(32'h00000004);
        exp_q.push_back(32'h00000062);
        exp_q.push_back(32'h50000006);

        // Clear for one cycle, then the T0 decode must be visible
        tick(1);
        clear = 1'b0;
        check_eq("reset_pc", dut.pc_q, 64'd0);
        check_eq("reset_step", dut.step_q, 64'd0);
        check_eq("reset_run", run, 64'd1);
        check_eq("reset_strobes", strobes, exp_t0);

        tick(3);
        check_eq("fetch_ir", dut.ir_q, prog[0]);
        tick(3);
        check_reg("ldi_r2", 2);
        tick(6);
        check_reg("ldi_r3", 3);
        tick(6);
        check_reg("ldi_r1", 1);
        tick(6);
        check_reg("add_r4", 4);
        tick(6);
        check_reg("ror_r5", 5);

        tick(7);
        check_eq("mul_lo", dut.lo_q, 64'hFFFFFED1);
        check_eq("mul_hi", dut.hi_q, 64'hFFFFFFFF);
        tick(7);
        check_eq("div_lo", dut.lo_q, 64'hFFFFFFDF);
        check_eq("div_hi", dut.hi_q, 64'h00000002);

        // Store: watch each step for Write
        wcnt = 0;
        wstep = -1;
        for (int s = 0; s < 8; s++) begin
            if (wr) begin
                wcnt++;
                wstep = s;
            end
            tick(1);
        end
        check_eq("st_write_count", wcnt, 64'd1);
        check_eq("st_write_step", wstep, 64'd7);
        check_eq("st_mem40", dut.mem[32'h40], 64'h65);

        tick(8);
        check_eq("ld_r6", dut.regs_q[6], 64'h65);

        tick(7);
        check_eq("br_taken_pc", dut.pc_q, 64'd12);

        tick(3);
        check_eq("halt_run", run, 64'd0);
        check_eq("halt_strobes", strobes, 64'd0);
        check_eq("halt_pc", dut.pc_q, 64'd13);
        tick(3);
        check_eq("halt_pc_frozen", dut.pc_q, 64'd13);
        check_eq("halt_run_frozen", run, 64'd0);
        check_eq("br_skipped_r8", dut.regs_q[8], 64'd0);

        // Stop mid-instruction, then resume from the frozen step
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(4);
        check_eq("stop_pre_step", dut.step_q, 64'd4);
        stop = 1'b1;
        #1;
        check_eq("stop_run", run, 64'd0);
        check_eq("stop_strobes", strobes, 64'd0);
        tick(3);
        check_eq("stop_step_frozen", dut.step_q, 64'd4);
        check_eq("stop_r2_held", dut.regs_q[2], 64'd0);
        stop = 1'b0;
        tick(2);
        check_eq("resume_r2", dut.regs_q[2], 64'h65);
        check_eq("resume_step", dut.step_q, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
